// File: rtl/pll_lock_supervisor_if.sv
// rtl/pll_lock_supervisor_if.sv - control/status bundle between the PLL lock supervisor and its surroundings
interface pll_lock_supervisor_if;
    logic       pll_locked;
    logic       restart_req;
    logic       pll_rst;
    logic [2:0] core_reset_n;
    logic       ready;
    logic       fail;
    logic [1:0] retry_count;
    logic [2:0] state;
    logic [7:0] lock_loss_count;

    // Supervisor side: consumes lock/restart, drives resets and status
    modport master (
        input  pll_locked,
        input  restart_req,
        output pll_rst,
        output core_reset_n,
        output ready,
        output fail,
        output retry_count,
        output state,
        output lock_loss_count
    );

    // PLL wrapper / software side
    modport slave (
        output pll_locked,
        output restart_req,
        input  pll_rst,
        input  core_reset_n,
        input  ready,
        input  fail,
        input  retry_count,
        input  state,
        input  lock_loss_count
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock sequencer with staged core reset release (optional PLLSUP_LOSS_COUNT_EN)
module pll_lock_supervisor #(
    parameter int RST_HOLD_CYCLES     = 64,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1048576,
    parameter int MAX_RETRIES         = 3,
    parameter int STAGE_GAP           = 16
) (
    input  logic                  clk_74a,
    input  logic                  reset_n,
    pll_lock_supervisor_if.master bus
);

    localparam int MAX_AB  = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ? RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_ABC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_P   = (MAX_ABC > 2 * STAGE_GAP + 1) ? MAX_ABC : 2 * STAGE_GAP + 1;
    localparam int CNT_W   = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_1        = CNT_W'(STAGE_GAP);
    localparam logic [CNT_W-1:0] GAP_2        = CNT_W'(2 * STAGE_GAP);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    logic             sync1_q, sync2_q;
    logic             locked_sync;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic             pll_rst_q, pll_rst_d;
    logic [2:0]       core_q, core_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    assign locked_sync = sync2_q;

    // Two-flop synchroniser for the asynchronous PLL lock indication
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.pll_locked;
            sync2_q <= sync1_q;
        end
    end

    // State, shared counter, retry count and registered outputs
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            retry_q   <= 2'd0;
            pll_rst_q <= 1'b1;
            core_q    <= 3'b000;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= pll_rst_d;
            core_q    <= core_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    // Next-state, retry and counter logic; restart overrides every transition
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock is checked before the terminal count so it wins a tie
                if (locked_sync) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + 2'd1;
                        state_d = S_HOLD;
                    end
                end
            end
            S_STABLE: begin
                if (!locked_sync)              state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!locked_sync) begin
                    state_d = S_HOLD;
                    retry_d = 2'd0;
                end else if (cnt_q == GAP_2) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!locked_sync) begin
                    state_d = S_HOLD;
                    retry_d = 2'd0;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
        if (bus.restart_req) begin
            state_d = S_HOLD;
            retry_d = 2'd0;
        end
        // Counter restarts on any transition or restart, otherwise counts up and parks at all-ones
        if (bus.restart_req || (state_d != state_q)) cnt_d = '0;
        else if (cnt_q != CNT_MAX)                   cnt_d = cnt_q + CNT_ONE;
    end

    // Output values derived from the upcoming state so they line up with the state register
    always_comb begin
        pll_rst_d = 1'b0;
        core_d    = 3'b000;
        ready_d   = 1'b0;
        fail_d    = 1'b0;
        case (state_d)
            S_HOLD: begin
                pll_rst_d = 1'b1;
            end
            S_FAIL: begin
                pll_rst_d = 1'b1;
                fail_d    = 1'b1;
            end
            S_RELEASE: begin
                core_d = core_q | {(cnt_d >= GAP_2), (cnt_d >= GAP_1), 1'b1};
            end
            S_RUN: begin
                core_d  = 3'b111;
                ready_d = 1'b1;
            end
            default: begin
                pll_rst_d = 1'b0;
            end
        endcase
    end

`ifdef PLLSUP_LOSS_COUNT_EN
    logic       run_loss;
    logic [7:0] loss_q;

    assign run_loss = (state_q == S_RUN) && !locked_sync && !bus.restart_req;

    // Saturating count of lock losses seen while running; only reset_n clears it
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n)                        loss_q <= 8'd0;
        else if (run_loss && loss_q != 8'hFF) loss_q <= loss_q + 8'd1;
    end

    assign bus.lock_loss_count = loss_q;
`else
    assign bus.lock_loss_count = 8'd0;
`endif

    assign bus.pll_rst      = pll_rst_q;
    assign bus.core_reset_n = core_q;
    assign bus.ready        = ready_q;
    assign bus.fail         = fail_q;
    assign bus.retry_count  = retry_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - randomized and directed bench for pll_lock_supervisor against a phase/time model
module tb_pll_lock_supervisor;
    localparam int RH = 4;
    localparam int ST = 8;
    localparam int TO = 32;
    localparam int MR = 2;
    localparam int G  = 3;

    logic clk_74a = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    pll_lock_supervisor_if bus();

    pll_lock_supervisor #(
        .RST_HOLD_CYCLES(RH),
        .LOCK_STABLE_CYCLES(ST),
        .LOCK_TIMEOUT_CYCLES(TO),
        .MAX_RETRIES(MR),
        .STAGE_GAP(G)
    ) dut (
        .clk_74a(clk_74a),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk_74a = ~clk_74a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase (0 hold,1 wait,2 stable,3 release,4 run,5 fail) and time spent in it
    typedef struct packed {
        int phase;
        int t;
        int retry;
        int loss;
    } mst_t;

    mst_t       m;
    logic [1:0] m_lh;

    function automatic mst_t mstep(input mst_t s, input logic ls, input logic rq);
        mst_t n;
        n = s;
        if (rq) begin
            n.phase = 0; n.t = 0; n.retry = 0;
            return n;
        end
        case (s.phase)
            0: if (s.t == RH - 1) begin n.phase = 1; n.t = 0; end else n.t = s.t + 1;
            1: begin
                if (ls) begin n.phase = 2; n.t = 0; end
                else if (s.t == TO - 1) begin
                    n.t = 0;
                    if (s.retry == MR) n.phase = 5;
                    else begin n.phase = 0; n.retry = s.retry + 1; end
                end else n.t = s.t + 1;
            end
            2: if (!ls) begin n.phase = 1; n.t = 0; end
               else if (s.t == ST - 1) begin n.phase = 3; n.t = 0; end
               else n.t = s.t + 1;
            3: if (!ls) begin n.phase = 0; n.t = 0; n.retry = 0; end
               else if (s.t == 2 * G) begin n.phase = 4; n.t = 0; end
               else n.t = s.t + 1;
            4: if (!ls) begin
                n.phase = 0; n.t = 0; n.retry = 0;
`ifdef PLLSUP_LOSS_COUNT_EN
                if (s.loss < 255) n.loss = s.loss + 1;
`endif
            end
            default: n = s;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] exp_core(input mst_t s);
        if (s.phase == 3) return {(s.t >= 2 * G), (s.t >= G), 1'b1};
        if (s.phase == 4) return 3'b111;
        return 3'b000;
    endfunction

    always @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            m    <= '0;
            m_lh <= 2'b00;
        end else begin
            m    <= mstep(m, m_lh[1], bus.restart_req);
            m_lh <= {m_lh[0], bus.pll_locked};
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk_74a) begin
        chk("m_state",   32'(bus.state),           32'(m.phase));
        chk("m_pll_rst", 32'(bus.pll_rst),         32'((m.phase == 0) || (m.phase == 5)));
        chk("m_core",    32'(bus.core_reset_n),    32'(exp_core(m)));
        chk("m_ready",   32'(bus.ready),           32'(m.phase == 4));
        chk("m_fail",    32'(bus.fail),            32'(m.phase == 5));
        chk("m_retry",   32'(bus.retry_count),     32'(m.retry));
        chk("m_loss",    32'(bus.lock_loss_count), 32'(m.loss));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_74a);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen1, seen2;
        int exp_loss;
`ifdef PLLSUP_LOSS_COUNT_EN
        exp_loss = 1;
`else
        exp_loss = 0;
`endif
        bus.pll_locked  = 1'b0;
        bus.restart_req = 1'b0;
        tick(3);
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_pll_rst", 32'(bus.pll_rst), 1);
        chk("rst_core", 32'(bus.core_reset_n), 0);
        chk("rst_ready", 32'(bus.ready), 0);
        chk("rst_fail", 32'(bus.fail), 0);
        chk("rst_retry", 32'(bus.retry_count), 0);

        // 1: normal bring-up
        @(posedge clk_74a); #1 reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.pll_rst) n++; else break;
        end
        chk("pll_rst_width", 32'(n), 4);
        tick(5);
        bus.pll_locked = 1'b1;
        for (int i = 0; i < 80 && bus.core_reset_n == 3'b000; i++) tick(1);
        chk("rel_stage0", 32'(bus.core_reset_n), 32'd1);
        tick(3);
        chk("rel_stage1", 32'(bus.core_reset_n), 32'd3);
        tick(3);
        chk("rel_stage2", 32'(bus.core_reset_n), 32'd7);
        chk("rel_ready_lo", 32'(bus.ready), 0);
        tick(1);
        chk("run_ready", 32'(bus.ready), 1);
        chk("run_state", 32'(bus.state), 4);

        // 4: lock loss in RUN
        bus.pll_locked = 1'b0;
        tick(3);
        chk("loss_state", 32'(bus.state), 0);
        chk("loss_core", 32'(bus.core_reset_n), 0);
        chk("loss_ready", 32'(bus.ready), 0);
        chk("loss_pll_rst", 32'(bus.pll_rst), 1);
        chk("loss_count", 32'(bus.lock_loss_count), 32'(exp_loss));

        // 2: one-cycle glitch at STABLE count 5
        bus.pll_locked = 1'b1;
        for (int i = 0; i < 40 && bus.state != 3'd2; i++) tick(1);
        chk("stable_reached", 32'(bus.state), 2);
        tick(5);
        bus.pll_locked = 1'b0;
        tick(1);
        bus.pll_locked = 1'b1;
        tick(2);
        chk("glitch_state", 32'(bus.state), 1);
        chk("glitch_retry", 32'(bus.retry_count), 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (bus.state == 3'd2) n++;
            else if (n > 0) break;
        end
        chk("stable_len", 32'(n), 8);
        chk("after_stable", 32'(bus.state), 3);

        // 3: retries exhausted
        for (int i = 0; i < 30 && bus.state != 3'd4; i++) tick(1);
        bus.pll_locked = 1'b0;
        seen1 = 0; seen2 = 0;
        for (int i = 0; i < 400 && bus.state != 3'd5; i++) begin
            tick(1);
            if (bus.retry_count == 2'd1) seen1 = 1;
            if (bus.retry_count == 2'd2 && seen1) seen2 = 1;
        end
        chk("retry_saw1", 32'(seen1), 1);
        chk("retry_saw2", 32'(seen2), 1);
        chk("fail_state", 32'(bus.state), 5);
        chk("fail_flag", 32'(bus.fail), 1);
        chk("fail_pll_rst", 32'(bus.pll_rst), 1);
        chk("fail_core", 32'(bus.core_reset_n), 0);

        // 5a: restart out of FAIL
        bus.restart_req = 1'b1;
        tick(1);
        bus.restart_req = 1'b0;
        chk("rs_fail_state", 32'(bus.state), 0);
        chk("rs_fail_fail", 32'(bus.fail), 0);
        chk("rs_fail_retry", 32'(bus.retry_count), 0);

        // 5b: restart on the WAIT_LOCK terminal-count cycle
        for (int i = 0; i < 20 && bus.state != 3'd1; i++) tick(1);
        tick(TO - 1);
        chk("to_edge_state", 32'(bus.state), 1);
        bus.restart_req = 1'b1;
        tick(1);
        bus.restart_req = 1'b0;
        chk("rs_to_state", 32'(bus.state), 0);
        chk("rs_to_fail", 32'(bus.fail), 0);
        chk("rs_to_retry", 32'(bus.retry_count), 0);

        // 6: asynchronous reset mid-RELEASE
        bus.pll_locked = 1'b1;
        for (int i = 0; i < 100 && bus.core_reset_n != 3'b011; i++) tick(1);
        chk("mid_release", 32'(bus.core_reset_n), 3);
        #1 reset_n = 1'b0;
        #1;
        chk("async_core", 32'(bus.core_reset_n), 0);
        chk("async_state", 32'(bus.state), 0);
        chk("async_pll_rst", 32'(bus.pll_rst), 1);
        chk("async_ready", 32'(bus.ready), 0);
        tick(2);
        @(posedge clk_74a); #1 reset_n = 1'b1;

        // Randomized lock behaviour and sporadic restarts, checked by the model each cycle
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if (bus.pll_locked) begin
                if ($urandom_range(0, 59) == 0) bus.pll_locked = 1'b0;
            end else begin
                if ($urandom_range(0, 24) == 0) bus.pll_locked = 1'b1;
            end
            bus.restart_req = ($urandom_range(0, 149) == 0);
        end
        bus.restart_req = 1'b0;
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Sequences the core clock PLL (74.25 MHz ref; outputs 85.9 MHz memory, 21.48 MHz main, 10.74 MHz video and its phase-shifted copy).
- Holds the PLL in reset, waits for a stable lock with a timeout and bounded retries.
- Releases the per-domain core resets in a staged order.
- Tears everything down again on lock loss or a software restart.
- Runs entirely in the 74.25 MHz reference domain, beside the PLL wrapper.

Parameters:
- RST_HOLD_CYCLES, 64: cycles pll_rst is held high per attempt.
- LOCK_STABLE_CYCLES, 1024: consecutive cycles locked_sync must stay high before release.
- LOCK_TIMEOUT_CYCLES, 1048576: cycles allowed in WAIT_LOCK per attempt.
- MAX_RETRIES, 3: timeouts tolerated before FAIL.
- STAGE_GAP, 16: cycles between successive core reset releases.

Ports:
- clk_74a, input, 1: 74.25 MHz reference clock; also the PLL refclk.
- reset_n, input, 1: asynchronous active-low reset.
- pll_locked, input, 1: raw PLL locked, asynchronous; 2-flop synchronised internally to locked_sync.
- restart_req, input, 1: single-cycle software restart pulse, clk_74a domain.
- pll_rst, output, 1: PLL reset, active high.
- core_reset_n, output, 3: [0] memory domain, [1] main domain, [2] video domains; active low.
- ready, output, 1: all domains out of reset, PLL locked.
- fail, output, 1: retries exhausted.
- retry_count, output, 2: timeouts in the current sequence, saturates at MAX_RETRIES.
- state, output, 3: encoded FSM state for debug.
- lock_loss_count, output, 8: see Optional Feature.

Behaviour:
Reset state (reset_n low, asynchronous):
- state=HOLD, pll_rst=1, core_reset_n=3'b000, ready=0, fail=0, retry_count=0.
- Counter=0, sync flops=0, lock_loss_count=0.

General rules:
- All outputs are registered.
- One shared cycle counter, width $clog2 of the largest parameter plus 1; cleared on every state change.
- State encoding: HOLD=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5.

FSM:
- HOLD: pll_rst=1, core_reset_n=000, ready=0. When the counter reaches RST_HOLD_CYCLES-1, go to WAIT_LOCK. pll_rst is high for exactly RST_HOLD_CYCLES cycles.
- WAIT_LOCK: pll_rst=0.
  - locked_sync=1: go to STABLE.
  - Else, when the counter reaches LOCK_TIMEOUT_CYCLES-1: if retry_count==MAX_RETRIES go to FAIL; else increment retry_count and go to HOLD.
- STABLE: pll_rst=0.
  - locked_sync=0: go to WAIT_LOCK. The timeout counter restarts; retry_count is unchanged.
  - Counter reaches LOCK_STABLE_CYCLES-1 with locked_sync still 1: go to RELEASE.
- RELEASE: release the core resets in order.
  - core_reset_n[0]=1 on the first RELEASE cycle.
  - core_reset_n[1]=1 at counter==STAGE_GAP.
  - core_reset_n[2]=1 at counter==2*STAGE_GAP.
  - Next cycle: go to RUN with ready=1.
  - Once released, a bit stays released until teardown.
- RUN: ready=1, core_reset_n=111. locked_sync=0 causes teardown.
- Teardown (locked_sync=0 in RELEASE or RUN):
  - Next cycle: core_reset_n=000, ready=0, state=HOLD, pll_rst=1, retry_count=0.
- FAIL: pll_rst=1, core_reset_n=000, fail=1. Only restart_req or reset_n leaves FAIL.
- restart_req: highest priority, accepted in any state. Next cycle: state=HOLD, counter=0, retry_count=0, fail=0, core_reset_n=000, ready=0.

Boundary conditions:
- restart_req arriving in the same cycle as a timeout or lock event: the restart wins.
- Lock assertion in the same cycle as the timeout terminal count: lock wins and the FSM goes to STABLE.
- Latency: pll_locked to locked_sync is 2 cycles, plus 1 cycle for the FSM reaction.

Optional Feature:
Macro: PLLSUP_LOSS_COUNT_EN.
- Defined: lock_loss_count increments by 1, saturating at 255, on every teardown from RUN. Teardowns from RELEASE do not count. Cleared only by reset_n; restart_req does not clear it.
- Undefined: lock_loss_count is constant 0 and no counter logic is built.

Test Plan:
Bench parameters: RST_HOLD_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2, STAGE_GAP=3.
1. Normal bring-up. Release reset_n; pll_locked=1 from cycle 10.
   - pll_rst high for exactly 4 cycles.
   - core_reset_n goes 001, then 011 three cycles later, then 111 three cycles after that.
   - ready=1 one cycle after 111; state=4.
2. Lock glitch in STABLE. Drop pll_locked for 1 cycle at STABLE count 5.
   - Returns to WAIT_LOCK, retry_count=0.
   - Full 8-cycle stability is required again before RELEASE.
3. Retries exhausted. pll_locked held 0.
   - retry_count counts 1, then 2.
   - After the third 32-cycle timeout: state=5, fail=1, pll_rst=1, core_reset_n=000.
4. Lock loss in RUN. Drop pll_locked while in RUN.
   - Within 3 cycles: core_reset_n=000, ready=0, pll_rst=1, state=0.
   - lock_loss_count=1 with PLLSUP_LOSS_COUNT_EN, 0 without.
5. restart_req from FAIL, and restart_req coincident with the WAIT_LOCK timeout cycle.
   - Both: state=0, fail=0, retry_count=0 on the next cycle.
6. Asynchronous reset_n assertion mid-RELEASE (core_reset_n=011).
   - Outputs return to reset values immediately, without a clock edge.
